// File: rtl/req_scan_rr.sv
// Round-robin request scanner: captures request events into a pending vector and
// offers one pending line index at a time on a valid/ready handshake.
module req_scan_rr #(
   parameter int unsigned N    = 8,
   parameter int unsigned W    = 3,
   parameter int unsigned EDGE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         idx_ready,
   input  logic         clr_ovf,
   output logic         idx_valid,
   output logic [W-1:0] idx,
   output logic [N-1:0] pending,
   output logic         overflow
);

   typedef enum logic {
      IDLE,
      OFFER
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] req_q;
   logic [W-1:0] ptr, ptr_nxt;
   logic [W-1:0] idx_nxt;
   logic         valid_nxt;
   logic [N-1:0] pend_nxt;
   logic         ovf_nxt;

   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic         acc;
   logic         found;
   logic [W-1:0] sel;
   logic [W-1:0] cand;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_q     <= '0;
         pending   <= '0;
         ptr       <= '0;
         idx       <= '0;
         idx_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         req_q     <= req;
         pending   <= pend_nxt;
         ptr       <= ptr_nxt;
         idx       <= idx_nxt;
         idx_valid <= valid_nxt;
         overflow  <= ovf_nxt;
      end
   end

   always_comb begin
      rise = (EDGE != 0) ? (req & ~req_q) : req;
      acc  = idx_valid & idx_ready;
      clr  = '0;
      if (acc) clr[idx] = 1'b1;

      // A rise on the line being accepted re-arms it rather than counting as lost.
      if (EDGE != 0) begin
         pend_nxt = (pending & ~clr) | rise;
         ovf_nxt  = (|(rise & pending & ~clr)) | (overflow & ~clr_ovf);
      end else begin
         pend_nxt = req;
         ovf_nxt  = 1'b0;
      end

      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = ptr + W'(k);
         if (!found && pending[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = idx;
      valid_nxt = idx_valid;
      case (state)
         IDLE: begin
            if (found) begin
               idx_nxt   = sel;
               valid_nxt = 1'b1;
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (acc) begin
               valid_nxt = 1'b0;
               ptr_nxt   = idx + W'(1);
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_req_scan_rr.sv
// Directed bench for req_scan_rr (edge mode): reset, round-robin order, backpressure,
// overflow flag behaviour, pointer wrap and reset during an offer.
module tb_req_scan_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       idx_ready;
   logic       clr_ovf;
   logic       idx_valid;
   logic [2:0] idx;
   logic [7:0] pending;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   req_scan_rr #(.N(8), .W(3), .EDGE(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .idx_ready (idx_ready),
      .clr_ovf   (clr_ovf),
      .idx_valid (idx_valid),
      .idx       (idx),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_pend;

      // Reset with all requests held high
      rst_n = 1'b0; req = 8'hFF; idx_ready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      check("rst_valid", {7'd0, idx_valid}, 8'h00);
      check("rst_idx", {5'd0, idx}, 8'h00);
      check("rst_pending", pending, 8'h00);
      check("rst_ovf", {7'd0, overflow}, 8'h00);
      rst_n = 1'b1;
      tick();
      check("rel_pending", pending, 8'hFF);
      check("rel_valid0", {7'd0, idx_valid}, 8'h00);
      tick();
      check("rel_valid1", {7'd0, idx_valid}, 8'h01);
      check("rel_idx", {5'd0, idx}, 8'h00);
      check("rel_ovf", {7'd0, overflow}, 8'h00);

      // Single pulse on line 5, then confirm scan resumes at 6
      do_reset();
      req = 8'h20; idx_ready = 1'b1;
      tick();
      check("p5_pending", pending, 8'h20);
      check("p5_valid0", {7'd0, idx_valid}, 8'h00);
      req = 8'h00;
      tick();
      check("p5_valid", {7'd0, idx_valid}, 8'h01);
      check("p5_idx", {5'd0, idx}, 8'h05);
      tick();
      check("p5_drop", {7'd0, idx_valid}, 8'h00);
      check("p5_pend0", pending, 8'h00);
      check("p5_idx_hold", {5'd0, idx}, 8'h05);
      req = 8'h41;
      tick();
      req = 8'h00;
      tick();
      check("ptr6_idx", {5'd0, idx}, 8'h06);
      check("ptr6_valid", {7'd0, idx_valid}, 8'h01);
      tick();
      check("ptr6_pend", pending, 8'h01);
      tick();
      check("ptr7_idx", {5'd0, idx}, 8'h00);
      check("ptr7_valid", {7'd0, idx_valid}, 8'h01);
      tick();
      check("ptr7_pend", pending, 8'h00);

      // All eight lines at once: strict 0..7 order with an idle cycle between grants
      do_reset();
      req = 8'hFF; idx_ready = 1'b1;
      tick();
      req = 8'h00;
      tick();
      for (int k = 0; k < 8; k++) begin
         check("all_valid", {7'd0, idx_valid}, 8'h01);
         check("all_idx", {5'd0, idx}, 8'(k));
         tick();
         exp_pend = 8'hFF << (k + 1);
         check("all_gap", {7'd0, idx_valid}, 8'h00);
         check("all_pend", pending, exp_pend);
         if (k < 7) tick();
      end
      check("all_ovf", {7'd0, overflow}, 8'h00);

      // Backpressure: offer of 3 stays put while line 0 arrives
      idx_ready = 1'b0;
      req = 8'h08;
      tick();
      req = 8'h00;
      tick();
      check("bp_idx0", {5'd0, idx}, 8'h03);
      for (int c = 0; c < 5; c++) begin
         req = (c == 1) ? 8'h01 : 8'h00;
         tick();
         check("bp_valid", {7'd0, idx_valid}, 8'h01);
         check("bp_idx", {5'd0, idx}, 8'h03);
      end
      check("bp_pend", pending, 8'h09);
      req = 8'h00; idx_ready = 1'b1;
      tick();
      check("bp_acc", {7'd0, idx_valid}, 8'h00);
      check("bp_acc_pend", pending, 8'h01);
      tick();
      check("bp_next_idx", {5'd0, idx}, 8'h00);
      check("bp_next_valid", {7'd0, idx_valid}, 8'h01);
      tick();
      idx_ready = 1'b0;

      // Overflow: set, clear, set-over-clear priority, no set on same-cycle accept
      req = 8'h04;
      tick();
      req = 8'h00;
      tick();
      check("ov_offer", {5'd0, idx}, 8'h02);
      req = 8'h04;
      tick();
      check("ov_set", {7'd0, overflow}, 8'h01);
      req = 8'h00; clr_ovf = 1'b1;
      tick();
      check("ov_clr", {7'd0, overflow}, 8'h00);
      req = 8'h04;
      tick();
      check("ov_prio", {7'd0, overflow}, 8'h01);
      req = 8'h00;
      tick();
      check("ov_clr2", {7'd0, overflow}, 8'h00);
      clr_ovf = 1'b0; req = 8'h04; idx_ready = 1'b1;
      tick();
      check("ov_acc_pend", pending, 8'h04);
      check("ov_acc_ovf", {7'd0, overflow}, 8'h00);
      check("ov_acc_valid", {7'd0, idx_valid}, 8'h00);
      req = 8'h00;
      tick();
      check("ov_reoffer", {5'd0, idx}, 8'h02);
      check("ov_reoffer_v", {7'd0, idx_valid}, 8'h01);
      tick();
      check("ov_drain", pending, 8'h00);

      // Wrap: after granting 6, lines 7 and 1 are served 7 then 1
      idx_ready = 1'b0;
      req = 8'h40;
      tick();
      req = 8'h00;
      tick();
      check("wr_idx6", {5'd0, idx}, 8'h06);
      req = 8'h82;
      tick();
      req = 8'h00; idx_ready = 1'b1;
      tick();
      check("wr_pend", pending, 8'h82);
      check("wr_gap", {7'd0, idx_valid}, 8'h00);
      tick();
      check("wr_idx7", {5'd0, idx}, 8'h07);
      tick();
      tick();
      check("wr_idx1", {5'd0, idx}, 8'h01);
      check("wr_valid1", {7'd0, idx_valid}, 8'h01);
      rst_n = 1'b0; idx_ready = 1'b0;
      tick();
      check("wr_rst_valid", {7'd0, idx_valid}, 8'h00);
      check("wr_rst_pend", pending, 8'h00);
      check("wr_rst_idx", {5'd0, idx}, 8'h00);
      rst_n = 1'b1;
      tick();
      tick();
      check("wr_idle", {7'd0, idx_valid}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/req_scan_rr.md
Name: req_scan_rr

Overview:
- Sequential request scanner sitting directly upstream of decoder_3x8.
- Captures events on 8 request lines into a pending register and selects one pending line at a time, round-robin.
- Presents the selected line's 3-bit index on a valid/ready handshake.
- The consumer drives idx into decoder_3x8 to produce a one-hot acknowledge/enable vector.

Parameters:
- N, 8, number of request lines (fixed at 8 for this revision; must equal 2**W).
- W, 3, index width.
- EDGE, 1, 1 = capture rising edges of req; 0 = level mode (pending mirrors req).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  request lines, sampled on clk.
- idx_ready  input  1  consumer accepts idx when high with idx_valid.
- clr_ovf  input  1  clears sticky overflow flag.
- idx_valid  output  1  idx holds a selected request.
- idx  output  W  index of selected line.
- pending  output  N  registered pending-request vector.
- overflow  output  1  sticky: an event was lost.

Behaviour:
- Reset, sampled at a rising edge with rst_n=0, forces the following to 0: req_q, pending, ptr, idx_valid, idx, overflow, and state=IDLE.
  - Reset mid-offer drops the offer; no handshake completes.
  - req_q is cleared to 0, so a req held high through reset is captured as a new event on the first edge after release.
- Event detect:
  - EDGE=1: rise = req & ~req_q, where req_q is req registered each cycle.
  - EDGE=0: rise = req.
- Accept: acc = idx_valid & idx_ready; clr = one-hot(idx) when acc, else 0.
- Pending update:
  - EDGE=1: pending <= (pending & ~clr) | rise. A rise on the line being accepted in the same cycle wins, so the bit stays set.
  - EDGE=0: pending <= req.
- Overflow (EDGE=1 only):
  - Set when any line has rise=1 and pending=1 and is not cleared that cycle.
  - Cleared by clr_ovf. Set has priority over clr_ovf in the same cycle.
  - In EDGE=0, overflow stays 0.
- FSM, 2 states:
  - IDLE: if registered pending != 0, select the first set bit scanning ptr, ptr+1, ... mod N. On that edge set idx <= selected, idx_valid <= 1, go to OFFER. Otherwise stay, with idx_valid=0.
  - OFFER: idx and idx_valid are held stable while idx_ready=0. No re-selection occurs, even if higher-priority lines arrive.
  - On acc: idx_valid <= 0, ptr <= (idx+1) mod N (wraps 7 to 0), go to IDLE. idx keeps its last value.
- Latency:
  - req rising before edge E0 gives pending[i]=1 after E0, and idx_valid=1 after E1.
  - Minimum 2 cycles per grant, because of one IDLE bubble after each accept.
- The selection is computed from registered pending only. An event arriving in the same cycle is not visible until the next cycle.
- idx_valid never drops without acc, except on reset.
- In EDGE=0 mode, a line deasserting while offered is still offered until accepted.
- Width rules:
  - ptr and idx are W bits; arithmetic is mod N.
  - All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset with req=8'hFF held, rst_n=0 for 2 cycles -> all outputs 0. After release: pending=8'hFF after 1 edge, then idx_valid=1 with idx=0.
2. One-cycle pulse on req[5], idx_ready=1 -> idx_valid high for exactly 1 cycle with idx=5; afterwards pending=0 and next scan starts at 6.
3. req=8'hFF single-cycle pulse, idx_ready=1 -> idx sequence 0,1,2,...,7, each valid 1 cycle separated by 1 idle cycle; pending reaches 0 after the 8th accept; overflow=0.
4. Backpressure: pulse req[3], idx_ready=0 for 5 cycles -> idx=3 and idx_valid=1 stable for all 5 cycles; pulse req[0] during the stall causes no change. Then idx_ready=1 -> 3 accepted, then 0 offered.
5. Overflow:
   - Pulse req[2] twice while idx_ready=0 -> overflow=1. Assert clr_ovf -> overflow=0.
   - Pulse req[2] again in the same cycle as clr_ovf -> overflow stays 1.
   - Rise on req[2] in the accept cycle of idx=2 -> pending[2] stays 1, overflow unchanged.
6. Wrap fairness: after accepting idx=6, pending={1,7} -> next offered 7, then 1. Reset asserted during the offer of 1 -> idx_valid=0 and pending=0 on the next edge.
